// File: rtl/sdram_request_arbiter.sv
// Serialises CPU read/write, PPU read and periodic refresh onto the one-command SDRAM controller port.
// IDLE selects work (urgent refresh > PPU > CPU > refresh), CMD pulses one mc_* line, WAIT holds until mc_busy drops.
module sdram_request_arbiter #(
    parameter int REFRESH_INTERVAL = 160,
    parameter int REFRESH_URGENT   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [21:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_done,
    input  logic        ppu_rd,
    input  logic [21:0] ppu_addr,
    output logic [7:0]  ppu_dout,
    output logic        ppu_done,
    output logic        mc_read_a,
    output logic        mc_read_b,
    output logic        mc_write,
    output logic        mc_refresh,
    output logic [21:0] mc_addr,
    output logic [7:0]  mc_din,
    input  logic [7:0]  mc_dout_a,
    input  logic [7:0]  mc_dout_b,
    input  logic        mc_busy,
    output logic        overrun,
    output logic        refresh_miss
);
    localparam int CW = $clog2(REFRESH_INTERVAL + 1);
    localparam int AW = $clog2(REFRESH_URGENT + 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT} state_t;
    typedef enum logic [1:0] {C_CPU_RD, C_CPU_WR, C_PPU_RD, C_REFRESH} cmd_t;

    state_t      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic [21:0] mc_addr_q, mc_addr_d;
    logic [7:0]  mc_din_q, mc_din_d;
    logic        cpu_vld_q, cpu_vld_d, cpu_op_wr_q, cpu_op_wr_d;
    logic [21:0] cpu_addr_q, cpu_addr_d;
    logic [7:0]  cpu_din_q, cpu_din_d;
    logic        ppu_vld_q, ppu_vld_d;
    logic [21:0] ppu_addr_q, ppu_addr_d;
    logic [CW-1:0] ref_cnt_q, ref_cnt_d;
    logic [1:0]  owed_q, owed_d;
    logic [AW-1:0] age_q, age_d;
    logic [7:0]  cpu_dout_q, cpu_dout_d, ppu_dout_q, ppu_dout_d;
    logic        cpu_done_q, cpu_done_d, ppu_done_q, ppu_done_d;
    logic        overrun_q, overrun_d, refresh_miss_q, refresh_miss_d;
    logic        tick, cpu_req, cpu_clr, ppu_clr, ref_dec;

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        mc_addr_d      = mc_addr_q;
        mc_din_d       = mc_din_q;
        cpu_vld_d      = cpu_vld_q;
        cpu_op_wr_d    = cpu_op_wr_q;
        cpu_addr_d     = cpu_addr_q;
        cpu_din_d      = cpu_din_q;
        ppu_vld_d      = ppu_vld_q;
        ppu_addr_d     = ppu_addr_q;
        owed_d         = owed_q;
        age_d          = age_q;
        cpu_dout_d     = cpu_dout_q;
        ppu_dout_d     = ppu_dout_q;
        cpu_done_d     = 1'b0;
        ppu_done_d     = 1'b0;
        overrun_d      = overrun_q;
        refresh_miss_d = refresh_miss_q;
        cpu_clr        = 1'b0;
        ppu_clr        = 1'b0;
        ref_dec        = 1'b0;
        cpu_req        = cpu_rd | cpu_wr;
        tick           = (ref_cnt_q == CW'(REFRESH_INTERVAL - 1));
        ref_cnt_d      = tick ? '0 : ref_cnt_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                if (!mc_busy && (cpu_vld_q || ppu_vld_q || owed_q != 2'd0)) begin
                    state_d = S_CMD;
                    if (owed_q != 2'd0 && age_q >= AW'(REFRESH_URGENT)) begin
                        cmd_d = C_REFRESH;
                    end else if (ppu_vld_q) begin
                        cmd_d     = C_PPU_RD;
                        mc_addr_d = ppu_addr_q;
                    end else if (cpu_vld_q) begin
                        cmd_d     = cpu_op_wr_q ? C_CPU_WR : C_CPU_RD;
                        mc_addr_d = cpu_addr_q;
                        mc_din_d  = cpu_din_q;
                    end else begin
                        cmd_d = C_REFRESH;
                    end
                end
            end
            S_CMD: state_d = S_WAIT;
            S_WAIT: begin
                if (!mc_busy) begin
                    state_d = S_IDLE;
                    case (cmd_q)
                        C_CPU_RD: begin
                            cpu_dout_d = mc_dout_a;
                            cpu_done_d = 1'b1;
                            cpu_clr    = 1'b1;
                        end
                        C_CPU_WR: begin
                            cpu_done_d = 1'b1;
                            cpu_clr    = 1'b1;
                        end
                        C_PPU_RD: begin
                            ppu_dout_d = mc_dout_b;
                            ppu_done_d = 1'b1;
                            ppu_clr    = 1'b1;
                        end
                        default: ref_dec = 1'b1;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A request landing on the edge that frees its slot is taken, not counted as overrun.
        if (cpu_clr) cpu_vld_d = 1'b0;
        if (cpu_req) begin
            if (!cpu_vld_q || cpu_clr) begin
                cpu_vld_d   = 1'b1;
                cpu_op_wr_d = cpu_wr;
                cpu_addr_d  = cpu_addr;
                cpu_din_d   = cpu_din;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (ppu_clr) ppu_vld_d = 1'b0;
        if (ppu_rd) begin
            if (!ppu_vld_q || ppu_clr) begin
                ppu_vld_d  = 1'b1;
                ppu_addr_d = ppu_addr;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (tick && !ref_dec) begin
            if (owed_q == 2'd3) refresh_miss_d = 1'b1;
            else owed_d = owed_q + 2'd1;
        end else if (!tick && ref_dec) begin
            owed_d = owed_q - 2'd1;
        end

        if (state_q == S_CMD && cmd_q == C_REFRESH) age_d = '0;
        else if (owed_q != 2'd0 && age_q != {AW{1'b1}}) age_d = age_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cmd_q          <= C_CPU_RD;
            mc_addr_q      <= '0;
            mc_din_q       <= '0;
            cpu_vld_q      <= 1'b0;
            cpu_op_wr_q    <= 1'b0;
            cpu_addr_q     <= '0;
            cpu_din_q      <= '0;
            ppu_vld_q      <= 1'b0;
            ppu_addr_q     <= '0;
            ref_cnt_q      <= '0;
            owed_q         <= '0;
            age_q          <= '0;
            cpu_dout_q     <= '0;
            ppu_dout_q     <= '0;
            cpu_done_q     <= 1'b0;
            ppu_done_q     <= 1'b0;
            overrun_q      <= 1'b0;
            refresh_miss_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            mc_addr_q      <= mc_addr_d;
            mc_din_q       <= mc_din_d;
            cpu_vld_q      <= cpu_vld_d;
            cpu_op_wr_q    <= cpu_op_wr_d;
            cpu_addr_q     <= cpu_addr_d;
            cpu_din_q      <= cpu_din_d;
            ppu_vld_q      <= ppu_vld_d;
            ppu_addr_q     <= ppu_addr_d;
            ref_cnt_q      <= ref_cnt_d;
            owed_q         <= owed_d;
            age_q          <= age_d;
            cpu_dout_q     <= cpu_dout_d;
            ppu_dout_q     <= ppu_dout_d;
            cpu_done_q     <= cpu_done_d;
            ppu_done_q     <= ppu_done_d;
            overrun_q      <= overrun_d;
            refresh_miss_q <= refresh_miss_d;
        end
    end

    assign mc_read_a    = (state_q == S_CMD) && (cmd_q == C_CPU_RD);
    assign mc_write     = (state_q == S_CMD) && (cmd_q == C_CPU_WR);
    assign mc_read_b    = (state_q == S_CMD) && (cmd_q == C_PPU_RD);
    assign mc_refresh   = (state_q == S_CMD) && (cmd_q == C_REFRESH);
    assign mc_addr      = mc_addr_q;
    assign mc_din       = mc_din_q;
    assign cpu_dout     = cpu_dout_q;
    assign ppu_dout     = ppu_dout_q;
    assign cpu_done     = cpu_done_q;
    assign ppu_done     = ppu_done_q;
    assign overrun      = overrun_q;
    assign refresh_miss = refresh_miss_q;
endmodule

// File: tb/tb_sdram_request_arbiter.sv
// Scoreboarded bench: randomized CPU/PPU traffic against a queue-based reference model and a controller model.
module tb_sdram_request_arbiter;
    localparam int BUSY_LEN = 4;
    localparam int R_RI     = 16;
    localparam int R_RU     = 64;
    localparam logic [21:0] R_ADDR = 22'h200040;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic cpu_rd, cpu_wr, ppu_rd;
    logic [21:0] cpu_addr, ppu_addr, mc_addr;
    logic [7:0] cpu_din, cpu_dout, ppu_dout, mc_din;
    logic cpu_done, ppu_done, mc_read_a, mc_read_b, mc_write, mc_refresh;
    logic [7:0] mc_dout_a = 8'h00, mc_dout_b = 8'h00;
    logic mc_busy, init_busy, overrun, refresh_miss;

    logic r_ppu_rd = 1'b0;
    logic [7:0] r_cpu_dout, r_ppu_dout, r_mc_din, r_mc_dout_b = 8'h00;
    logic r_cpu_done, r_ppu_done, r_mc_read_a, r_mc_read_b, r_mc_write, r_mc_refresh;
    logic [21:0] r_mc_addr;
    logic r_mc_busy, r_overrun, r_refresh_miss;

    sdram_request_arbiter dut (
        .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_done(cpu_done), .ppu_rd(ppu_rd),
        .ppu_addr(ppu_addr), .ppu_dout(ppu_dout), .ppu_done(ppu_done), .mc_read_a(mc_read_a),
        .mc_read_b(mc_read_b), .mc_write(mc_write), .mc_refresh(mc_refresh), .mc_addr(mc_addr),
        .mc_din(mc_din), .mc_dout_a(mc_dout_a), .mc_dout_b(mc_dout_b), .mc_busy(mc_busy),
        .overrun(overrun), .refresh_miss(refresh_miss));

    sdram_request_arbiter #(.REFRESH_INTERVAL(R_RI), .REFRESH_URGENT(R_RU)) dut_r (
        .clk(clk), .reset(reset), .cpu_rd(1'b0), .cpu_wr(1'b0), .cpu_addr(22'h0),
        .cpu_din(8'h00), .cpu_dout(r_cpu_dout), .cpu_done(r_cpu_done), .ppu_rd(r_ppu_rd),
        .ppu_addr(R_ADDR), .ppu_dout(r_ppu_dout), .ppu_done(r_ppu_done), .mc_read_a(r_mc_read_a),
        .mc_read_b(r_mc_read_b), .mc_write(r_mc_write), .mc_refresh(r_mc_refresh), .mc_addr(r_mc_addr),
        .mc_din(r_mc_din), .mc_dout_a(8'h00), .mc_dout_b(r_mc_dout_b), .mc_busy(r_mc_busy),
        .overrun(r_overrun), .refresh_miss(r_refresh_miss));

    int n_total = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [7:0] fdat(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'hA5;
    endfunction

    // Controller model: busy for BUSY_LEN cycles after each command, small tagged memory.
    int unsigned bcnt = 0, r_bcnt = 0;
    logic [21:0] cm_tag [256];
    logic [7:0]  cm_dat [256];
    bit          cm_v   [256];
    assign mc_busy   = init_busy || (bcnt != 0);
    assign r_mc_busy = (r_bcnt != 0);

    always @(posedge clk) begin
        if (mc_read_a | mc_read_b | mc_write | mc_refresh) begin
            bcnt <= BUSY_LEN;
            if (mc_read_a)
                mc_dout_a <= (cm_v[mc_addr[7:0]] && cm_tag[mc_addr[7:0]] == mc_addr) ? cm_dat[mc_addr[7:0]] : fdat(mc_addr);
            if (mc_read_b) mc_dout_b <= fdat(mc_addr);
            if (mc_write) begin
                cm_v[mc_addr[7:0]]   <= 1'b1;
                cm_tag[mc_addr[7:0]] <= mc_addr;
                cm_dat[mc_addr[7:0]] <= mc_din;
            end
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
        end
        if (r_mc_read_a | r_mc_read_b | r_mc_write | r_mc_refresh) begin
            r_bcnt <= BUSY_LEN;
            if (r_mc_read_b) r_mc_dout_b <= fdat(r_mc_addr);
        end else if (r_bcnt != 0) begin
            r_bcnt <= r_bcnt - 1;
        end
    end

    // Reference model state
    typedef struct {logic wr; logic [21:0] addr; logic [7:0] din; logic [7:0] rdat;} cop_t;
    cop_t cpu_q[$];
    logic [21:0] ppu_q[$];
    logic [7:0] ref_mem [logic [21:0]];
    int cpu_out_n = 0, ppu_out_n = 0;
    logic exp_overrun = 1'b0;
    logic [7:0] exp_cpu_dout = 8'h00, exp_ppu_dout = 8'h00;
    int cmd_log[$], done_log[$];
    int n_rda = 0, n_cmd = 0, n_ref = 0, n_cpud = 0, n_ppud = 0;

    task automatic cpu_req(input bit wr, input bit rd_too, input logic [21:0] a, input logic [7:0] d, input bit frees);
        cop_t op;
        cpu_rd = wr ? rd_too : 1'b1;
        cpu_wr = wr;
        cpu_addr = a;
        cpu_din = d;
        if (cpu_out_n != 0 && !frees) begin
            exp_overrun = 1'b1;
        end else begin
            op.wr = wr; op.addr = a; op.din = d; op.rdat = 8'h00;
            if (wr) ref_mem[a] = d;
            else op.rdat = ref_mem.exists(a) ? ref_mem[a] : fdat(a);
            cpu_q.push_back(op);
            cpu_out_n++;
        end
    endtask

    task automatic ppu_req(input logic [21:0] a);
        ppu_rd = 1'b1;
        ppu_addr = a;
        if (ppu_out_n != 0) exp_overrun = 1'b1;
        else begin
            ppu_q.push_back(a);
            ppu_out_n++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0; ppu_rd = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int c = 0;
        while ((cpu_q.size() != 0 || ppu_q.size() != 0 || mc_busy) && c < maxc) begin
            step();
            c++;
        end
        chk("drain", 32'(cpu_q.size() + ppu_q.size()), 0);
    endtask

    // Monitor: commands checked against the head of each port's queue, completions popped and compared.
    always @(negedge clk) begin : mon
        int n;
        cop_t op;
        logic [21:0] pa;
        if (!reset) begin
            n = int'(mc_read_a) + int'(mc_read_b) + int'(mc_write) + int'(mc_refresh);
            if (n != 0) begin
                n_cmd++;
                chk("one_cmd", 32'(n), 1);
            end
            if (mc_read_a) begin
                n_rda++; cmd_log.push_back(0);
                chk("rd_a_pending", 32'(cpu_q.size() != 0), 1);
                if (cpu_q.size() != 0) begin
                    chk("rd_a_is_read", 32'(cpu_q[0].wr), 0);
                    chk("rd_a_addr", 32'(mc_addr), 32'(cpu_q[0].addr));
                end
            end
            if (mc_write) begin
                cmd_log.push_back(2);
                chk("wr_pending", 32'(cpu_q.size() != 0), 1);
                if (cpu_q.size() != 0) begin
                    chk("wr_is_write", 32'(cpu_q[0].wr), 1);
                    chk("wr_addr", 32'(mc_addr), 32'(cpu_q[0].addr));
                    chk("wr_din", 32'(mc_din), 32'(cpu_q[0].din));
                end
            end
            if (mc_read_b) begin
                cmd_log.push_back(1);
                chk("rd_b_pending", 32'(ppu_q.size() != 0), 1);
                if (ppu_q.size() != 0) chk("rd_b_addr", 32'(mc_addr), 32'(ppu_q[0]));
            end
            if (mc_refresh) begin
                n_ref++; cmd_log.push_back(3);
            end
            if (cpu_done) begin
                n_cpud++; done_log.push_back(0);
                chk("cpu_done_expected", 32'(cpu_q.size() != 0), 1);
                if (cpu_q.size() != 0) begin
                    op = cpu_q.pop_front();
                    cpu_out_n--;
                    if (!op.wr) exp_cpu_dout = op.rdat;
                end
                chk("cpu_dout", 32'(cpu_dout), 32'(exp_cpu_dout));
            end
            if (ppu_done) begin
                n_ppud++; done_log.push_back(1);
                chk("ppu_done_expected", 32'(ppu_q.size() != 0), 1);
                if (ppu_q.size() != 0) begin
                    pa = ppu_q.pop_front();
                    ppu_out_n--;
                    exp_ppu_dout = fdat(pa);
                end
                chk("ppu_dout", 32'(ppu_dout), 32'(exp_ppu_dout));
            end
        end
    end

    // Refresh-starvation scenario on the short-interval instance with PPU requesting every cycle.
    bit r_finished = 1'b0;
    initial begin : rmon
        int first_ref, nrb, exp_ref, exp_nrb, idle0;
        first_ref = -1;
        nrb = 0;
        // IDLE opportunities fall on cycles 1+7k; refresh wins the first one at or after age URGENT.
        idle0 = 1 + 7 * ((R_RI + R_RU - 1 + 6) / 7);
        exp_ref = idle0 + 1;
        exp_nrb = (exp_ref - 2 + 6) / 7;
        wait (reset === 1'b0);
        for (int c = 0; c <= exp_ref + 10; c++) begin
            @(negedge clk);
            if (r_mc_read_a || r_mc_write) chk("r_no_cpu_cmd", {r_mc_read_a, r_mc_write}, 0);
            if (r_mc_read_b) begin
                if (first_ref < 0) nrb++;
                chk("r_rd_b_addr", 32'(r_mc_addr), 32'(R_ADDR));
            end
            if (r_ppu_done) chk("r_ppu_dout", 32'(r_ppu_dout), 32'(fdat(R_ADDR)));
            if (c == 4 * R_RI - 2) chk("r_miss_before_4th_tick", 32'(r_refresh_miss), 0);
            if (r_mc_refresh && first_ref < 0) begin
                first_ref = c;
                chk("r_miss_at_refresh", 32'(r_refresh_miss), 1);
                chk("r_reads_before_refresh", 32'(nrb), 32'(exp_nrb));
            end
            if (c == exp_ref + 7) chk("r_ppu_after_refresh", 32'(r_mc_read_b), 1);
        end
        chk("r_first_refresh_cycle", 32'(first_ref), 32'(exp_ref));
        chk("r_overrun", 32'(r_overrun), 1);
        chk("r_cpu_idle", {r_cpu_done, r_cpu_dout, r_mc_din}, 0);
        r_finished = 1'b1;
    end

    initial begin : main
        int n0, d0;
        cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_din = 0; ppu_rd = 0; ppu_addr = 0;
        init_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        r_ppu_rd = 1'b1;
        @(negedge clk);
        chk("rst_cpu_dout", 32'(cpu_dout), 0);
        chk("rst_ppu_dout", 32'(ppu_dout), 0);
        chk("rst_done", {cpu_done, ppu_done}, 0);
        chk("rst_cmds", {mc_read_a, mc_read_b, mc_write, mc_refresh}, 0);
        chk("rst_mc_addr", 32'(mc_addr), 0);
        chk("rst_mc_din", 32'(mc_din), 0);
        chk("rst_flags", {overrun, refresh_miss}, 0);

        // Controller busy from init for 20 cycles; CPU read waits in its slot.
        step(); step();
        cpu_req(1'b0, 1'b0, 22'h000123, 8'h00, 1'b0);
        for (int c = 2; c < 20; c++) step();
        chk("no_cmd_while_busy", 32'(n_cmd), 0);
        init_busy = 1'b0;
        wait_idle(100);
        chk("t1_one_read_a", 32'(n_rda), 1);

        // Idle-path latency: command cycle 2, done cycle 8.
        ppu_req(22'h200010);
        step();
        step();
        @(negedge clk);
        chk("lat_cmd_c2", 32'(mc_read_b), 1);
        repeat (5) step();
        @(negedge clk);
        chk("lat_no_done_c7", 32'(ppu_done), 0);
        step();
        @(negedge clk);
        chk("lat_done_c8", 32'(ppu_done), 1);
        chk("lat_data_c8", 32'(ppu_dout), 32'(fdat(22'h200010)));
        wait_idle(50);

        // Simultaneous CPU write and PPU read: PPU served first.
        cmd_log.delete(); done_log.delete();
        cpu_req(1'b1, 1'b0, 22'h380005, 8'h5A, 1'b0);
        ppu_req(22'h200010);
        step();
        wait_idle(100);
        chk("t3_cmd_count", 32'(cmd_log.size()), 2);
        chk("t3_done_count", 32'(done_log.size()), 2);
        if (cmd_log.size() == 2 && done_log.size() == 2) begin
            chk("t3_cmd_order", {cmd_log[0][7:0], cmd_log[1][7:0]}, 16'h0102);
            chk("t3_done_order", {done_log[0][7:0], done_log[1][7:0]}, 16'h0100);
        end

        // Request on the very cycle its slot frees is taken without overrun.
        n0 = n_rda; d0 = n_cpud;
        cpu_req(1'b0, 1'b0, 22'h004007, 8'h00, 1'b0);
        repeat (7) step();
        cpu_req(1'b0, 1'b0, 22'h004008, 8'h00, 1'b1);
        step();
        wait_idle(100);
        chk("free_edge_overrun", 32'(overrun), 32'(exp_overrun));
        chk("free_edge_reads", 32'(n_rda - n0), 2);
        chk("free_edge_dones", 32'(n_cpud - d0), 2);

        // Second CPU read while the first is in flight is dropped.
        n0 = n_rda; d0 = n_cpud;
        cpu_req(1'b0, 1'b0, 22'h004001, 8'h00, 1'b0);
        step(); step(); step();
        cpu_req(1'b0, 1'b0, 22'h004002, 8'h00, 1'b0);
        step();
        wait_idle(100);
        chk("ovr_flag", 32'(overrun), 32'(exp_overrun));
        chk("ovr_one_read", 32'(n_rda - n0), 1);
        chk("ovr_one_done", 32'(n_cpud - d0), 1);

        // Randomized mixed traffic.
        for (int i = 0; i < 1500; i++) begin
            if (cpu_out_n == 0 && $urandom_range(0, 2) == 0)
                cpu_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        22'h004000 | 22'($urandom_range(0, 15)), 8'($urandom), 1'b0);
            if (ppu_out_n == 0 && $urandom_range(0, 2) == 0)
                ppu_req(22'h200000 | 22'($urandom_range(0, 16'hFFFF)));
            step();
        end
        wait_idle(200);
        chk("rand_overrun_sticky", 32'(overrun), 32'(exp_overrun));
        chk("rand_no_refresh_miss", 32'(refresh_miss), 0);
        chk("rand_refresh_seen", 32'(n_ref > 0), 1);

        // Reset while a CPU read is in WAIT: no completion, everything back to reset values.
        cpu_req(1'b0, 1'b0, 22'h004003, 8'h00, 1'b0);
        step();
        for (int c = 0; c < 200 && !mc_read_a; c++) @(negedge clk);
        chk("rst_test_cmd_seen", 32'(mc_read_a), 1);
        step();
        cpu_q.delete(); cpu_out_n = 0;
        exp_overrun = 1'b0; exp_cpu_dout = 8'h00; exp_ppu_dout = 8'h00;
        d0 = n_cpud;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_dout", {cpu_dout, ppu_dout}, 0);
        chk("mid_rst_done", {cpu_done, ppu_done}, 0);
        chk("mid_rst_cmds", {mc_read_a, mc_read_b, mc_write, mc_refresh}, 0);
        chk("mid_rst_mc", {mc_addr, mc_din}, 0);
        chk("mid_rst_flags", {overrun, refresh_miss}, 0);
        repeat (15) step();
        chk("mid_rst_no_done", 32'(n_cpud - d0), 0);
        cpu_req(1'b0, 1'b0, 22'h004004, 8'h00, 1'b0);
        step();
        wait_idle(100);
        chk("post_rst_done", 32'(n_cpud - d0), 1);

        for (int c = 0; c < 500 && !r_finished; c++) step();
        chk("refresh_scenario_finished", 32'(r_finished), 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end
endmodule
